// File: rtl/timer_set_ctrl_pkg.sv
// rtl/timer_set_ctrl_pkg.sv - timer_pkg: setting-mode states, default parameters, counter width helper
package timer_pkg;

    typedef enum logic [1:0] {
        ST_NORMAL   = 2'd0,
        ST_SET_MIN  = 2'd1,
        ST_SET_HOUR = 2'd2
    } set_state_t;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 16;
    localparam int unsigned DEF_TIMEOUT_CYCLES  = 4096;
    localparam int unsigned DEF_BLINK_HALF      = 256;
    localparam int unsigned DEF_REPEAT_DELAY    = 512;
    localparam int unsigned DEF_REPEAT_PERIOD   = 128;

    // Bits needed to hold the values 0..max_count.
    function automatic int unsigned cnt_width(input int unsigned max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/timer_set_ctrl_if.sv
// rtl/timer_set_ctrl_if.sv - key inputs and setting-mode outputs of timer_set_ctrl
interface timer_set_ctrl_if;
    logic key_mode;
    logic key_adj;
    logic min;
    logic hour;
    logic in2;
    logic blink;
    logic mode_chg;

    modport master (
        output key_mode, key_adj,
        input  min, hour, in2, blink, mode_chg
    );

    modport slave (
        input  key_mode, key_adj,
        output min, hour, in2, blink, mode_chg
    );
endinterface

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - 2-flop synchronizer, debounce counter and registered press pulse
module key_debounce
    import timer_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic level,
    output logic press
);
    localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // The counter only advances while the synchronized level disagrees with
    // the accepted level, so any bounce back restarts the qualification.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            sync1 <= key;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync2;
                cnt   <= '0;
                press <= sync2;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

// File: rtl/timer_set_ctrl.sv
// rtl/timer_set_ctrl.sv - setting-mode FSM, idle timeout, blink; ADJ auto-repeat under TIMER_SET_AUTOREPEAT_EN
module timer_set_ctrl
    import timer_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES,
    parameter int unsigned BLINK_HALF      = DEF_BLINK_HALF,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic            clk,
    input  logic            rst,
    timer_set_ctrl_if.slave bus
);
    localparam int unsigned IW = cnt_width(TIMEOUT_CYCLES);
    localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_CYCLES - 1);
    localparam int unsigned BW = cnt_width(BLINK_HALF);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

    logic          mode_ev;
    logic          adj_ev;
    logic          mode_level;
    logic          adj_level;
    set_state_t    state_q;
    set_state_t    state_d;
    logic          in_set;
    logic          adj_accept;
    logic          rep_hit;
    logic          timeout_hit;
    logic [IW-1:0] idle_cnt;
    logic [BW-1:0] blink_cnt;
    logic          min_d, hour_d, in2_d, chg_d;
    logic          min_q, hour_q, in2_q, blink_q, chg_q;
    logic          unused_mode_level;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_key (
        .clk   (clk),
        .rst   (rst),
        .key   (bus.key_mode),
        .level (mode_level),
        .press (mode_ev)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_adj_key (
        .clk   (clk),
        .rst   (rst),
        .key   (bus.key_adj),
        .level (adj_level),
        .press (adj_ev)
    );

    assign unused_mode_level = mode_level;

    // MODE beats ADJ in the same cycle; any activity beats the timeout.
    assign in_set      = (state_q != ST_NORMAL);
    assign adj_accept  = adj_ev && in_set && !mode_ev;
    assign timeout_hit = in_set && (idle_cnt == IDLE_LAST) && !mode_ev && !adj_ev && !rep_hit;

`ifdef TIMER_SET_AUTOREPEAT_EN
    localparam int unsigned RW = cnt_width((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

    logic          rep_on;
    logic          rep_steady;
    logic [RW-1:0] rep_cnt;

    assign rep_hit = rep_on && adj_level && in_set && !mode_ev &&
                     (rep_cnt == (rep_steady ? PERIOD_LAST : DELAY_LAST));

    always_ff @(posedge clk) begin
        if (rst) begin
            rep_on     <= 1'b0;
            rep_steady <= 1'b0;
            rep_cnt    <= '0;
        end else if (adj_accept) begin
            rep_on     <= 1'b1;
            rep_steady <= 1'b0;
            rep_cnt    <= '0;
        end else if (!rep_on || !adj_level || (state_d != state_q)) begin
            rep_on     <= 1'b0;
            rep_steady <= 1'b0;
            rep_cnt    <= '0;
        end else if (rep_hit) begin
            rep_steady <= 1'b1;
            rep_cnt    <= '0;
        end else begin
            rep_cnt <= rep_cnt + RW'(1);
        end
    end
`else
    logic unused_repeat_cfg;

    assign unused_repeat_cfg = ^{adj_level, 32'(REPEAT_DELAY), 32'(REPEAT_PERIOD)};
    assign rep_hit           = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_NORMAL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (mode_ev) begin
            case (state_q)
                ST_NORMAL:   state_d = ST_SET_MIN;
                ST_SET_MIN:  state_d = ST_SET_HOUR;
                default:     state_d = ST_NORMAL;
            endcase
        end else if (timeout_hit) begin
            state_d = ST_NORMAL;
        end
    end

    // Outputs are decoded from the next state and registered below.
    always_comb begin
        min_d  = (state_d == ST_SET_MIN);
        hour_d = (state_d == ST_SET_HOUR);
        chg_d  = (state_d != state_q);
        in2_d  = adj_accept || rep_hit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            min_q  <= 1'b0;
            hour_q <= 1'b0;
            in2_q  <= 1'b0;
            chg_q  <= 1'b0;
        end else begin
            min_q  <= min_d;
            hour_q <= hour_d;
            in2_q  <= in2_d;
            chg_q  <= chg_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || (state_d == ST_NORMAL) || chg_d || adj_ev || rep_hit) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + IW'(1);
        end
    end

    // Entering a set state restarts the blink phase with the field shown.
    always_ff @(posedge clk) begin
        if (rst || (state_d == ST_NORMAL)) begin
            blink_q   <= 1'b0;
            blink_cnt <= '0;
        end else if (chg_d) begin
            blink_q   <= 1'b1;
            blink_cnt <= '0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_q   <= !blink_q;
            blink_cnt <= '0;
        end else begin
            blink_cnt <= blink_cnt + BW'(1);
        end
    end

    assign bus.min      = min_q;
    assign bus.hour     = hour_q;
    assign bus.in2      = in2_q;
    assign bus.blink    = blink_q;
    assign bus.mode_chg = chg_q;
endmodule

// File: tb/tb_timer_set_ctrl.sv
// tb/tb_timer_set_ctrl.sv - randomized bench for timer_set_ctrl against a cycle-level reference model
module tb_timer_set_ctrl;
    localparam int D    = 16;
    localparam int T    = 4096;
    localparam int B    = 256;
    localparam int RD   = 512;
    localparam int RP   = 128;
    localparam int MAXC = 32768;
`ifdef TIMER_SET_AUTOREPEAT_EN
    localparam int HOLD_PULSES = 5;
`else
    localparam int HOLD_PULSES = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    timer_set_ctrl_if bus ();

    timer_set_ctrl #(
        .DEBOUNCE_CYCLES (D),
        .TIMEOUT_CYCLES  (T),
        .BLINK_HALF      (B),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    bit raw_key [2][MAXC];
    bit deb [2];
    bit ev_prev [2];
    int cyc, st, last_out, enter_c, last_adj_e, last_chg;
    int n_in2, n_chg, first_chg;
    bit both_seen;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic bit raw_at(input int k, input int i);
        return (i < 0) ? 1'b0 : raw_key[k][i];
    endfunction

    task automatic model_reset();
        cyc        = 0;
        st         = 0;
        deb        = '{1'b0, 1'b0};
        ev_prev    = '{1'b0, 1'b0};
        last_out   = 0;
        enter_c    = 0;
        last_adj_e = -1;
        last_chg   = -1;
    endtask

    // Expected {min, hour, in2, blink, mode_chg} for cycle cyc, from the key history.
    task automatic model_step(output logic [4:0] exp);
        int t, s, ns;
        bit mode, adj, rep, tmo, chg, in2, blk, flip;
        t    = cyc;
        s    = st;
        mode = ev_prev[0];
        adj  = ev_prev[1] && (s != 0) && !mode;
        rep  = 1'b0;
`ifdef TIMER_SET_AUTOREPEAT_EN
        if (s != 0 && !mode && deb[1] && last_adj_e >= 0 && last_chg <= last_adj_e) begin
            int d;
            d   = t - 1 - last_adj_e;
            rep = (d == RD) || (d > RD && ((d - RD) % RP) == 0);
        end
`endif
        tmo = (s != 0) && !mode && !adj && !rep && (t - last_out == T);
        ns  = mode ? (s + 1) % 3 : (tmo ? 0 : s);
        chg = (ns != s);
        in2 = adj || rep;
        if (chg) begin
            last_chg = t;
            last_out = t;
            if (ns != 0) enter_c = t;
        end
        if (in2) last_out = t;
        if (adj) last_adj_e = t - 1;
        blk = (ns != 0) && ((((t - enter_c) / B) % 2) == 0);
        st  = ns;
        exp = {ns == 1, ns == 2, in2, blk, chg};
        // A level flips once D consecutive synchronized samples disagree with it.
        for (int k = 0; k < 2; k++) begin
            flip = 1'b1;
            for (int j = t - D - 2; j <= t - 3; j++)
                if (raw_at(k, j) == deb[k]) flip = 1'b0;
            ev_prev[k] = flip && !deb[k];
            if (flip) deb[k] = !deb[k];
        end
    endtask

    task automatic tick(input bit km, input bit ka);
        logic [4:0] exp, got;
        if (cyc >= MAXC) begin
            $display("FAIL cycle_budget: cycle %0d, limit %0d", cyc, MAXC);
            $fatal(1, "model table exhausted");
        end
        bus.key_mode = km;
        bus.key_adj  = ka;
        raw_key[0][cyc] = km;
        raw_key[1][cyc] = ka;
        @(posedge clk);
        #1;
        cyc++;
        model_step(exp);
        got = {bus.min, bus.hour, bus.in2, bus.blink, bus.mode_chg};
        chk("outs", 32'(got), 32'(exp));
        if (bus.in2) n_in2++;
        if (bus.mode_chg) begin
            n_chg++;
            if (first_chg < 0) first_chg = cyc;
        end
        if (bus.min && bus.hour) both_seen = 1'b1;
    endtask

    task automatic hold(input bit km, input bit ka, input int n);
        repeat (n) tick(km, ka);
    endtask

    task automatic do_reset(input int n, input bit km, input bit ka);
        rst          = 1'b1;
        bus.key_mode = km;
        bus.key_adj  = ka;
        repeat (n) @(posedge clk);
        #1;
        chk("rst_outs", 32'({bus.min, bus.hour, bus.in2, bus.blink, bus.mode_chg}), 32'd0);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        bus.key_mode = 1'b0;
        bus.key_adj  = 1'b0;
        model_reset();
        do_reset(3, 1'b0, 1'b0);

        first_chg = -1; n_chg = 0;
        hold(1, 0, 40); hold(0, 0, 40);
        chk("first_chg_cycle", first_chg, D + 3);
        chk("press_min", bus.min, 1);
        chk("press_chg_count", n_chg, 1);

        n_in2 = 0;
        hold(0, 1, 10); hold(0, 0, 40);
        chk("glitch_in2", n_in2, 0);
        chk("glitch_min", bus.min, 1);

        n_in2 = 0;
        hold(0, 1, 1000); hold(0, 0, 60);
        chk("hold_in2", n_in2, HOLD_PULSES);

        n_in2 = 0; n_chg = 0;
        hold(1, 1, 30); hold(0, 0, 30);
        chk("simul_in2", n_in2, 0);
        chk("simul_hour", bus.hour, 1);
        chk("simul_chg", n_chg, 1);

        n_chg = 0;
        hold(0, 0, T + 10);
        chk("timeout_hour", bus.hour, 0);
        chk("timeout_blink", bus.blink, 0);
        chk("timeout_chg", n_chg, 1);

        n_chg = 0; both_seen = 1'b0;
        repeat (3) begin
            hold(1, 0, 30); hold(0, 0, 30);
        end
        chk("three_chg", n_chg, 3);
        chk("three_normal", {bus.min, bus.hour}, 0);
        chk("never_both", both_seen, 0);

        for (int i = 0; i < 100; i++) begin
            bit km, ka;
            int len;
            km  = 1'($urandom_range(0, 1));
            ka  = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(100, 700)) : int'($urandom_range(1, 40));
            hold(km, ka, len);
        end

        hold(0, 0, 40);
        for (int i = 0; i < 3 && st != 1; i++) begin
            hold(1, 0, 30); hold(0, 0, 30);
        end
        chk("pre_rst_min", bus.min, 1);
        hold(0, 1, 8);
        do_reset(1, 1'b1, 1'b1);

        first_chg = -1; n_in2 = 0;
        hold(1, 1, 40); hold(0, 0, 30);
        chk("held_rst_chg", first_chg, D + 3);
        chk("held_rst_in2", n_in2, 0);
        chk("held_rst_min", bus.min, 1);

        for (int i = 0; i < 40; i++) begin
            bit km, ka;
            km = 1'($urandom_range(0, 1));
            ka = 1'($urandom_range(0, 1));
            hold(km, ka, int'($urandom_range(1, 60)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
